uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit path: accepts one parallel word via valid/ready, then shifts out a
//   frame on the serial line: start bit, data bits LSB first, optional parity, stop bit(s).
//   Bit timing comes from the external baud generator's baud_tick_tx strobe.
//   Sits between the TX controller/FIFO and the pad; mirror of the RX bit-counting path.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, legal 5..9
//   STOP_BITS   1   stop bits per frame, legal 1 or 2
//   PARITY_ODD  0   with UART_TX_PARITY_EN: 0 = even parity, 1 = odd parity
// PORTS
//   clk           in   1          system clock, all logic on posedge
//   rst           in   1          synchronous, active-high reset
//   baud_tick_tx  in   1          one-clk strobe per bit period
//   tx_valid      in   1          parallel word available
//   tx_data       in   DATA_BITS  word to send, sampled at accept
//   tx_ready      out  1          block can accept a word
//   tx            out  1          serial line, idle high
//   tx_busy       out  1          frame in progress (accepted, not yet finished)
//   done_tx       out  1          one-clk pulse at end of last stop bit
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): tx=1, tx_ready=1, tx_busy=0, done_tx=0, state=IDLE,
//     shift reg and counters cleared. Reset mid-frame: frame abandoned, tx=1 next cycle, no done_tx.
//   States: IDLE -> ARM -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   Accept: tx_valid && tx_ready at posedge; tx_data latched to shift reg; next cycle
//     state=ARM, tx_ready=0, tx_busy=1. tx_data/tx_valid ignored until tx_ready returns.
//   All non-IDLE transitions advance only on baud_tick_tx; other cycles hold state and tx.
//   ARM: tx=1; on tick -> START, tx=0. A tick in the accept cycle itself does not count,
//     so every bit, start included, lasts exactly one full tick interval.
//   START: on tick -> DATA, tx=shift[0], bit count=0.
//   DATA: on tick, if count<DATA_BITS-1: shift right, count+1, tx=next bit;
//     else -> PARITY (if enabled) or STOP with tx=1.
//   PARITY: tx = ^data_latched ^ PARITY_ODD; on tick -> STOP, tx=1.
//   STOP: tx=1; on tick, if stop count<STOP_BITS-1: stop count+1; else -> IDLE,
//     done_tx=1 for exactly one clk, tx_ready=1, tx_busy=0 in the same cycle.
//   Back-to-back: word accepted in cycle after done_tx goes to ARM; next start bit
//     begins on the following tick, so there is no extra idle bit between frames.
//   Counters: bit count $clog2(DATA_BITS) bits, never wraps (bounded by FSM);
//     stop count 1 bit.
//   tx is registered (glitch-free at the pad); frame length in ticks =
//     1 + DATA_BITS + P + STOP_BITS, P = 1 with parity, else 0.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state present, parity bit sent per PARITY_ODD.
//   Undefined: no PARITY state, DATA goes straight to STOP, PARITY_ODD unused.
// STRUCTURE
//   uart_pkg: state encoding typedef (IDLE..STOP), LINE_IDLE=1'b1, START_BIT=1'b0,
//     legal-range constants for DATA_BITS/STOP_BITS, shared with the RX side.
//   Sub-module bit_counter_tx: en + baud_tick_tx driven counter with terminal-count pulse,
//     counts DATA_BITS ticks in DATA; FSM and shift register stay in uart_tx_serializer.
// TESTING (baud_tick_tx every 16 clk unless stated)
//   8N1, send 0xA5 -> tx per tick: 0,1,0,1,0,0,1,0,1,1; each bit 16 clk; done_tx 1 clk pulse.
//   Tick in accept cycle -> start bit begins at next tick, not that one; start bit full 16 clk.
//   Back-to-back 0x01 then 0xFF, tx_valid held high -> second accept cycle after done_tx;
//     no idle gap; tx_valid held while busy never causes a second accept mid-frame.
//   UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0.
//   STOP_BITS=2, send 0x00 -> tx high for 2 ticks after bit 7; done_tx after the second.
//   rst pulse during DATA bit 3 -> tx=1, tx_ready=1, tx_busy=0 next cycle; no done_tx;
//     a new word then sends a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, legal parameter ranges.
// Used by both the TX serializer and the RX side.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } uart_state_e;

  // Parity over a word of up to DATA_BITS_MAX bits. Zero-extension does not change the XOR.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bit_counter.sv
// Data-bit counter for the TX frame: counts baud ticks while enabled, clears when disabled.
// Latency: tc_o is combinational, asserted in the tick cycle of the last data bit.
// No backpressure; the FSM bounds the count, so it never wraps.
module bit_counter_tx #(
  parameter int WIDTH = 3,
  parameter int LAST  = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic tick_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] LAST_C = WIDTH'(LAST);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc_o = en_i && tick_i && (cnt_q == LAST_C);

  // Advance on each tick while enabled, hold at the terminal value, clear when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != LAST_C)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: start bit, DATA_BITS LSB first, optional parity (UART_TX_PARITY_EN), stop bits.
// Latency: start bit begins on the first baud tick after accept; one tick per bit, tx registered.
// Backpressure: tx_ready is low from accept until the done_tx cycle; tx_valid is ignored meanwhile.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 done_tx
);

  import uart_pkg::*;

  localparam int   CNT_W     = $clog2(DATA_BITS);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  // Reject parameter values outside the supported frame formats at elaboration.
  if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX) ||
      (STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX) ||
      (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_param
    $error("uart_tx_serializer: unsupported DATA_BITS/STOP_BITS/PARITY_ODD");
  end

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_cnt_q;
  logic                 tx_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 done_tx_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic data_en;
  logic data_last;

  assign data_en = (state_q == ST_DATA);

  bit_counter_tx #(
    .WIDTH (CNT_W),
    .LAST  (DATA_BITS - 1)
  ) u_bit_counter_tx (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (data_en),
    .tick_i (baud_tick_tx),
    .tc_o   (data_last)
  );

  // Frame FSM with registered line and handshake outputs; every non-IDLE move waits for a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      done_tx_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_tx_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A tick in this cycle is deliberately ignored so the start bit gets a full period.
          if (tx_valid && tx_ready_q) begin
            shift_q    <= tx_data;
            stop_cnt_q <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            state_q    <= ST_ARM;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_bit(DATA_BITS_MAX'(tx_data), 1'(PARITY_ODD));
`endif
          end
        end
        ST_ARM: begin
          if (baud_tick_tx) begin
            tx_q    <= START_BIT;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick_tx) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick_tx) begin
            if (!data_last) begin
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q    <= shift_q[1];
            end else begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= LINE_IDLE;
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick_tx) begin
            tx_q    <= LINE_IDLE;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick_tx) begin
            if (stop_cnt_q != STOP_LAST) begin
              stop_cnt_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b0;
              done_tx_q  <= 1'b1;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_q       <= LINE_IDLE;
          tx_ready_q <= 1'b1;
          tx_busy_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign done_tx  = done_tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8N1 even, 8-2stop odd) on a shared 16-clk baud tick.
// Expected line bits are queued when a word is driven and popped as each bit period starts.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick;
  int         tick_cnt = 0;

  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  logic       sel = 1'b0;
  logic       ready_m, tx_m, busy_m, done_m;

  int         checks = 0;
  int         errors = 0;
  logic       exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) tick_cnt <= (tick_cnt == 15) ? 0 : tick_cnt + 1;
  assign tick = (tick_cnt == 15);

  assign ready_m = sel ? ready_b : ready_a;
  assign tx_m    = sel ? tx_b    : tx_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .baud_tick_tx(tick), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .done_tx(done_a)
  );

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .baud_tick_tx(tick), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .done_tx(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_bits(input logic s);
    return 1 + 8 + P + (s ? 2 : 1);
  endfunction

  // Scoreboard push: reference frame for word d on instance s.
  task automatic push_frame(input logic s, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (P == 1) exp_q.push_back((^d) ^ s);
    for (int i = 0; i < (s ? 2 : 1); i++) exp_q.push_back(1'b1);
  endtask

  // Wait for ready, optionally line up the accept edge with a tick edge, then hand over one word.
  task automatic start_frame(input logic s, input logic [7:0] d, input bit align, input bit hold);
    int w;
    sel = s;
    w = 0;
    while (!ready_m && w < 400) begin @(posedge clk); #1; w++; end
    chk("ready_wait", ready_m, 1);
    if (align) begin
      w = 0;
      while (!tick && w < 20) begin @(posedge clk); #1; w++; end
      chk("align_tick", tick, 1);
    end
    if (s) begin valid_b = 1'b1; data_b = d; end
    else   begin valid_a = 1'b1; data_a = d; end
    push_frame(s, d);
    @(posedge clk); #1;
    if (!hold) begin valid_a = 1'b0; valid_b = 1'b0; end
  endtask

  // Called at the sample just after the accept edge; follows the frame to its done_tx cycle.
  task automatic run_frame(input int n, output int arm);
    int   bit_idx = 0;
    int   cyc = 0;
    logic eb = 1'b1;
    bit   fin = 1'b0;
    arm = 0;
    for (int c = 0; c < (n + 2) * 16 + 4 && !fin; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (tick_cnt == 0) begin
          if (bit_idx > 0) chk("bit_len", cyc, 16);
          bit_idx++;
          cyc = 0;
          if (bit_idx <= n) eb = exp_q.pop_front();
        end
      end
      if (bit_idx == n + 1) begin
        chk("done_pulse", done_m, 1);
        chk("done_ready", ready_m, 1);
        chk("done_busy", busy_m, 0);
        chk("done_tx_line", tx_m, 1);
        fin = 1'b1;
      end else begin
        chk("no_done", done_m, 0);
        chk("busy_ready", ready_m, 0);
        chk("busy", busy_m, 1);
        chk(bit_idx == 0 ? "arm_line" : "tx_bit", tx_m, bit_idx == 0 ? 1'b1 : eb);
        if (bit_idx == 0) arm++;
        cyc++;
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int arm;
    int arm2;
    int edges;
    int w;

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_a", tx_a, 1);     chk("rst_ready_a", ready_a, 1);
    chk("rst_busy_a", busy_a, 0); chk("rst_done_a", done_a, 0);
    chk("rst_tx_b", tx_b, 1);     chk("rst_ready_b", ready_b, 1);
    chk("rst_busy_b", busy_b, 0); chk("rst_done_b", done_b, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 0xA5.
    start_frame(1'b0, 8'hA5, 1'b0, 1'b0);
    run_frame(frame_bits(1'b0), arm);

    // Accept on a tick edge: that tick must not start the frame.
    start_frame(1'b0, 8'h3C, 1'b1, 1'b0);
    run_frame(frame_bits(1'b0), arm);
    chk("accept_tick_arm", arm, 16);

    // Back-to-back 0x01 then 0xFF with tx_valid held throughout.
    start_frame(1'b0, 8'h01, 1'b0, 1'b1);
    data_a = 8'hFF;
    push_frame(1'b0, 8'hFF);
    run_frame(frame_bits(1'b0), arm);
    @(posedge clk); #1;
    valid_a = 1'b0;
    run_frame(frame_bits(1'b0), arm2);
    chk("b2b_no_gap_arm", arm2, 15);

    // Two stop bits, 0x00.
    start_frame(1'b1, 8'h00, 1'b0, 1'b0);
    run_frame(frame_bits(1'b1), arm);

    // 0x07 on both instances (parity even on a, odd on b when enabled).
    start_frame(1'b0, 8'h07, 1'b0, 1'b0);
    run_frame(frame_bits(1'b0), arm);
    start_frame(1'b1, 8'h07, 1'b0, 1'b0);
    run_frame(frame_bits(1'b1), arm);

    // Reset during data bit 3 of 0x96.
    start_frame(1'b0, 8'h96, 1'b0, 1'b0);
    edges = 0;
    w = 0;
    while (edges < 5 && w < 200) begin
      @(posedge clk); #1;
      w++;
      if (tick_cnt == 0) edges++;
    end
    chk("pre_rst_edges", edges, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_d3", tx_a, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_ready", ready_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", done_a, 0);
      chk("post_rst_idle", tx_a, 1);
    end
    start_frame(1'b0, 8'h5A, 1'b0, 1'b0);
    run_frame(frame_bits(1'b0), arm);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
